// File: rtl/sdr_capture_seq.sv
// Capture sequencer for the clk250 receive chain: gates FIFO writes, pre-fills, issues reads,
// releases the NCO on the first read and aligns an I/Q-valid strobe to the mixer pipeline.
module sdr_capture_seq #(
    parameter int unsigned FILL_LEVEL = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned PIPE_LAT   = 18,
    parameter int unsigned LVL_W      = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [CNT_W-1:0] burst_len_i,
    input  logic [LVL_W-1:0] fifo_level_i,
    output logic             wr_en_o,
    output logic             rd_en_o,
    output logic             osc_rst_o,
    output logic             iq_valid_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] words_o,
    output logic             underflow_o,
    output logic             overflow_o
);

    localparam int unsigned DCW = $clog2(PIPE_LAT);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StRun,
        StDrain,
        StDone
    } state_e;

    state_e              r_state;
    state_e              w_state_d;
    logic                r_wr_en;
    logic                r_rd_en;
    logic                r_osc_rst;
    logic                r_busy;
    logic                r_done;
    logic [CNT_W-1:0]    r_words;
    logic [CNT_W-1:0]    w_words_d;
    logic [CNT_W-1:0]    r_burst;
    logic [DCW-1:0]      r_drain_cnt;
    logic [PIPE_LAT-1:0] r_valid_sr;
    logic                r_uf;
    logic                r_of;
    logic                w_start_ok;
    logic                w_rd_d;

    always_comb begin
        w_state_d  = r_state;
        w_start_ok = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start_i) begin
                    w_state_d  = StFill;
                    w_start_ok = 1'b1;
                end
            end
            StFill: begin
                if (stop_i) begin
                    w_state_d = StDrain;
                end else if (fifo_level_i >= LVL_W'(FILL_LEVEL)) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                // r_words already counts the read issued this cycle
                if (stop_i || ((r_burst != '0) && (r_words == r_burst))) begin
                    w_state_d = StDrain;
                end
            end
            StDrain: begin
                if (r_drain_cnt == DCW'(PIPE_LAT - 1)) begin
                    w_state_d = StDone;
                end
            end
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    always_comb begin
        w_rd_d    = (w_state_d == StRun);
        w_words_d = r_words;
        if (w_start_ok) begin
            w_words_d = '0;
        end else if (w_rd_d && (r_words != '1)) begin
            w_words_d = r_words + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= StIdle;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_osc_rst   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_words     <= '0;
            r_burst     <= '0;
            r_drain_cnt <= '0;
            r_valid_sr  <= '0;
            r_uf        <= 1'b0;
            r_of        <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_wr_en     <= (w_state_d == StFill) || (w_state_d == StRun);
            r_rd_en     <= w_rd_d;
            r_osc_rst   <= (w_state_d == StIdle) || (w_state_d == StFill) ||
                           (w_state_d == StDone);
            r_busy      <= (w_state_d != StIdle);
            r_done      <= (w_state_d == StDone);
            r_words     <= w_words_d;
            r_drain_cnt <= (r_state == StDrain) ? r_drain_cnt + 1'b1 : '0;
            r_valid_sr  <= {r_valid_sr[PIPE_LAT-2:0], r_rd_en};
            if (w_start_ok) begin
                r_burst <= burst_len_i;
                r_uf    <= 1'b0;
                r_of    <= 1'b0;
            end else begin
                r_uf <= r_uf | (r_rd_en && (fifo_level_i == '0));
                r_of <= r_of | (r_wr_en && (fifo_level_i >= LVL_W'(FIFO_DEPTH - 1)));
            end
        end
    end

    assign wr_en_o     = r_wr_en;
    assign rd_en_o     = r_rd_en;
    assign osc_rst_o   = r_osc_rst;
    assign iq_valid_o  = r_valid_sr[PIPE_LAT-1];
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign words_o     = r_words;
    assign underflow_o = r_uf;
    assign overflow_o  = r_of;

endmodule

// File: tb/tb_sdr_capture_seq.sv
// Bench for sdr_capture_seq: directed capture table plus random captures, each checked cycle by
// cycle against a timeline derived from the capture rules (fill end, run span, drain length).
module tb_sdr_capture_seq;

    localparam int PL = 18;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [15:0] burst_len;
    logic [4:0]  level;
    logic        wr_en_o, rd_en_o, osc_rst_o, iq_valid_o, busy_o, done_o;
    logic [15:0] words_o;
    logic        underflow_o, overflow_o;

    sdr_capture_seq dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .stop_i      (stop),
        .burst_len_i (burst_len),
        .fifo_level_i(level),
        .wr_en_o     (wr_en_o),
        .rd_en_o     (rd_en_o),
        .osc_rst_o   (osc_rst_o),
        .iq_valid_o  (iq_valid_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .words_o     (words_o),
        .underflow_o (underflow_o),
        .overflow_o  (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned burst;
        int          stop_at;
        int          mode;
        int          exp_words;
        bit          exp_uf;
        bit          exp_of;
    } dvec_t;

    dvec_t tbl[8];
    int    lvl[256];
    int    nvec;
    int    nerr;
    int    prev_words;
    bit    prev_uf;
    bit    prev_of;

    function automatic logic [23:0] pack(input bit wr, input bit rd, input bit osc, input bit iq,
                                         input bit busy, input bit done, input int words,
                                         input bit uf, input bit of);
        logic [15:0] w;
        w = words[15:0];
        return {wr, rd, osc, iq, busy, done, w, uf, of};
    endfunction

    function automatic logic [23:0] act_vec();
        return {wr_en_o, rd_en_o, osc_rst_o, iq_valid_o, busy_o, done_o, words_o,
                underflow_o, overflow_o};
    endfunction

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One capture starting from IDLE; cycle 0 is the cycle start is driven.
    task automatic run_capture(input int unsigned burst, input int stop_at, input int mode,
                               output int got_words, output bit got_uf, output bit got_of);
        bit has_run;
        int r, e, d, len, words_e;
        bit uf_acc, of_acc, rd_c, wr_c, iq_c;
        logic [23:0] exp;
        has_run = 0; r = 0; e = 0; d = 0;
        for (int c = 0; c < 256; c++) begin
            case (mode)
                0:       lvl[c] = (c == 0) ? 0 : ((c - 1 > 8) ? 8 : c - 1);
                1:       lvl[c] = (c == 0) ? 0 : ((c <= 9) ? c - 1 : 0);
                2:       lvl[c] = 15;
                default: lvl[c] = (c >= 20) ? 12 : int'($urandom_range(0, 15));
            endcase
        end
        for (int c = 1; c < 200; c++) begin
            if (c == stop_at) begin
                d = c + 1;
                break;
            end else if (lvl[c] >= 8) begin
                has_run = 1;
                r = c + 1;
                break;
            end
        end
        if (has_run) begin
            for (int c = r; c < 250; c++) begin
                if (c == stop_at || (burst != 0 && c - r + 1 == int'(burst))) begin
                    e = c;
                    d = c + 1;
                    break;
                end
            end
        end
        words_e = has_run ? e - r + 1 : 0;
        len = d + 20;
        uf_acc = 0; of_acc = 0;
        got_words = 0; got_uf = 0; got_of = 0;
        for (int c = 0; c < len; c++) begin
            @(negedge clk);
            rd_c = has_run && c >= r && c <= e;
            wr_c = c >= 1 && c <= d - 1;
            iq_c = c >= PL && has_run && (c - PL) >= r && (c - PL) <= e;
            if (c == 0) begin
                exp = pack(0, 0, 1, 0, 0, 0, prev_words, prev_uf, prev_of);
            end else begin
                exp = pack(wr_c, rd_c,
                           !(c >= (has_run ? r : d) && c <= d + 17), iq_c,
                           c <= d + 18, c == d + 18,
                           !has_run ? 0 : (c < r ? 0 : (c <= e ? c - r + 1 : words_e)),
                           uf_acc, of_acc);
            end
            check($sformatf("cycle%0d", c), act_vec(), exp);
            if (c == len - 1) begin
                got_words = int'(words_o);
                got_uf = underflow_o;
                got_of = overflow_o;
            end
            if (c >= 1 && rd_c && lvl[c] == 0) uf_acc = 1;
            if (c >= 1 && wr_c && lvl[c] >= 15) of_acc = 1;
            level = lvl[c][4:0];
            start = (c == 0) || (c >= 1 && c <= d + 18 && $urandom_range(0, 9) == 0);
            stop = (c == stop_at) || (c == len - 1);
            burst_len = (c == 0) ? burst[15:0] : 16'($urandom);
        end
        prev_words = words_e;
        prev_uf = uf_acc;
        prev_of = of_acc;
    endtask

    initial begin
        int gw;
        bit gu, go;
        int unsigned b;
        int sa;
        nvec = 0; nerr = 0;
        prev_words = 0; prev_uf = 0; prev_of = 0;
        rst = 1; start = 0; stop = 0; burst_len = '0; level = '0;

        repeat (3) @(negedge clk);
        check("reset_state", act_vec(), pack(0, 0, 1, 0, 0, 0, 0, 0, 0));
        rst = 0;

        // Reset pulse while running
        @(negedge clk);
        start = 1; burst_len = 16'd0; level = 5'd8;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 20 && !rd_en_o; i++) @(negedge clk);
        check("reach_run", {23'd0, rd_en_o}, 24'd1);
        repeat (5) @(negedge clk);
        #2 rst = 1;
        #1 check("reset_in_run", act_vec(), pack(0, 0, 1, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 0; level = 5'd0;
        @(negedge clk);
        check("idle_after_reset", act_vec(), pack(0, 0, 1, 0, 0, 0, 0, 0, 0));

        tbl[0] = '{burst: 5, stop_at: -1,  mode: 0, exp_words: 5,   exp_uf: 0, exp_of: 0};
        tbl[1] = '{burst: 0, stop_at: 109, mode: 0, exp_words: 100, exp_uf: 0, exp_of: 0};
        tbl[2] = '{burst: 3, stop_at: -1,  mode: 1, exp_words: 3,   exp_uf: 1, exp_of: 0};
        tbl[3] = '{burst: 5, stop_at: 4,   mode: 0, exp_words: 0,   exp_uf: 0, exp_of: 0};
        tbl[4] = '{burst: 4, stop_at: -1,  mode: 2, exp_words: 4,   exp_uf: 0, exp_of: 1};
        tbl[5] = '{burst: 1, stop_at: -1,  mode: 0, exp_words: 1,   exp_uf: 0, exp_of: 0};
        tbl[6] = '{burst: 5, stop_at: 9,   mode: 0, exp_words: 0,   exp_uf: 0, exp_of: 0};
        tbl[7] = '{burst: 5, stop_at: 14,  mode: 0, exp_words: 5,   exp_uf: 0, exp_of: 0};

        for (int t = 0; t < 8; t++) begin
            run_capture(tbl[t].burst, tbl[t].stop_at, tbl[t].mode, gw, gu, go);
            check($sformatf("tbl%0d_words", t), 24'(gw), 24'(tbl[t].exp_words));
            check($sformatf("tbl%0d_flags", t), {22'd0, gu, go},
                  {22'd0, tbl[t].exp_uf, tbl[t].exp_of});
        end

        for (int n = 0; n < 25; n++) begin
            b = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 30);
            sa = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 60)) : -1;
            if (b == 0 && sa < 0) sa = int'($urandom_range(1, 60));
            run_capture(b, sa, 3, gw, gu, go);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
